// File: rtl/bcd_seg_scan.sv
// Three-digit multiplexed 7-segment driver: shadows a BCD value on load and scans
// ones/tens/hundreds with a dead-time blank at the start of every digit slot.
module bcd_seg_scan #(
    parameter int DIV      = 50000,
    parameter int DEAD     = 16,
    parameter int BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
    localparam bit LZ_EN = (BLANK_LZ != 0);

    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    idx_reg, idx_next;
    logic [3:0]    sh_o_reg, sh_t_reg, sh_h_reg;
    logic [6:0]    seg_reg, seg_next;
    logic [2:0]    an_reg, an_next;
    logic          frame_tick_reg, frame_tick_next;
    logic          slot_last;

    logic [3:0] digit     [3];
    logic [6:0] dec_seg   [3];
    logic [2:0] lz_blank;

    function automatic logic [6:0] bcd_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign digit[0] = sh_o_reg;
    assign digit[1] = sh_t_reg;
    assign digit[2] = sh_h_reg;

    // Invalid codes are non-zero, so a dash in hundreds keeps tens visible.
    assign lz_blank[0] = 1'b0;
    assign lz_blank[1] = (sh_h_reg == 4'd0) && (sh_t_reg == 4'd0);
    assign lz_blank[2] = (sh_h_reg == 4'd0);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            assign dec_seg[gi] = (LZ_EN && lz_blank[gi]) ? 7'h7F : bcd_decode(digit[gi]);
        end
    endgenerate

    assign slot_last = (cnt_reg == CNT_LAST);

    always_comb begin
        cnt_next = slot_last ? '0 : cnt_reg + CW'(1);
        idx_next = idx_reg;
        if (slot_last) begin
            idx_next = (idx_reg == 2'd2) ? 2'd0 : idx_reg + 2'd1;
        end
    end

    // Outputs are computed from the current state and registered, giving one cycle of latency.
    always_comb begin
        an_next         = 3'b111;
        seg_next        = 7'h7F;
        frame_tick_next = slot_last && (idx_reg == 2'd2);
        if (cnt_reg >= CNT_DEAD) begin
            case (idx_reg)
                2'd0: begin
                    an_next  = 3'b110;
                    seg_next = dec_seg[0];
                end
                2'd1: begin
                    an_next  = 3'b101;
                    seg_next = dec_seg[1];
                end
                2'd2: begin
                    an_next  = 3'b011;
                    seg_next = dec_seg[2];
                end
                default: begin
                    an_next  = 3'b111;
                    seg_next = 7'h7F;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            idx_reg        <= 2'd0;
            sh_o_reg       <= 4'd0;
            sh_t_reg       <= 4'd0;
            sh_h_reg       <= 4'd0;
            seg_reg        <= 7'h7F;
            an_reg         <= 3'b111;
            frame_tick_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            seg_reg        <= seg_next;
            an_reg         <= an_next;
            frame_tick_reg <= frame_tick_next;
            if (load) begin
                sh_o_reg <= ones;
                sh_t_reg <= tens;
                sh_h_reg <= hundreds;
            end
        end
    end

    assign seg        = seg_reg;
    assign an         = an_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: doc/bcd_seg_scan.md
BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DIV, 50000: clocks per digit slot (≥ DEAD+2).
- DEAD, 16: clocks at the start of each slot with all anodes off (anti-ghosting).
- BLANK_LZ, 1: 1 = leading-zero blanking enabled.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock; all state on its rising edge.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- load, in, 1: one-cycle strobe capturing the digit inputs.
- ones, in, 4: BCD units digit.
- tens, in, 4: BCD tens digit.
- hundreds, in, 4: BCD hundreds digit.
- seg, out, 7: segments {g,f,e,d,c,b,a}, active-low.
- an, out, 3: digit anodes {hundreds,tens,ones}, active-low.
- frame_tick, out, 1: one-cycle pulse per completed 3-digit scan.

REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low. Ports clk and rst_n; polarity and synchronicity fixed.

Function
REQ-004 Shadow registers sh_o, sh_t, sh_h SHALL capture ones/tens/hundreds on any edge with load=1. Display uses only shadow values; inputs are ignored when load=0.

REQ-005 Slot counter cnt SHALL count 0..DIV-1 and wrap to 0. Digit index idx SHALL advance 0→1→2→0 on the edge where cnt=DIV-1 (0=ones, 1=tens, 2=hundreds).

REQ-006 Phase from (cnt, idx):
- cnt < DEAD: BLANK phase.
- otherwise: DRIVE phase for digit idx.

REQ-007 seg, an and frame_tick SHALL be registered. They reflect the (cnt, idx, shadow) state of the previous cycle (1-cycle latency).

REQ-008 BLANK phase outputs: an=3'b111, seg=7'h7F.

REQ-009 DRIVE phase outputs:
- an: only the selected bit low (idx0→3'b110, idx1→3'b101, idx2→3'b011).
- seg: decode of the selected shadow digit.

REQ-010 Decode table (hex, active-low):
- 0=40, 1=79, 2=24, 3=30, 4=19
- 5=12, 6=02, 7=78, 8=00, 9=10
- Any value 10..15 → 3F (dash, g only).

REQ-011 Leading-zero blanking with BLANK_LZ=1:
- Digit 2 blanked when sh_h==0.
- Digit 1 blanked when sh_h==0 and sh_t==0.
- Ones digit never blanked.
- A blanked digit drives seg=7'h7F but keeps its anode low.
- An invalid digit (>9) counts as non-zero.

REQ-012 With BLANK_LZ=0 all three digits SHALL always be decoded.

REQ-013 frame_tick SHALL be high for exactly one cycle, one cycle after the edge where idx wraps 2→0.

REQ-014 load concurrent with a slot or digit change: the new shadow value SHALL first appear on the output cycle following the capture edge. No partial-digit mixing within a cycle.

REQ-015 At most one an bit SHALL be low in any cycle.

Reset
REQ-016 While rst_n=0 the block SHALL immediately hold:
- cnt=0, idx=0
- sh_o=sh_t=sh_h=0
- an=3'b111, seg=7'h7F, frame_tick=0
This applies regardless of clk, including mid-slot.

REQ-017 After rst_n deasserts, the first edge SHALL begin slot 0 (ones) in BLANK phase. With default shadows, ones shows "0" (seg=40) from cycle DEAD+1.

Verification (DIV=8, DEAD=2 unless stated)
REQ-018 Reset release, no load → cycles 1-2 an=111 seg=7F; cycles 3-8 an=110 seg=40. Tens and hundreds slots show an low with seg=7F (blanked zeros).

REQ-019 load with h=1, t=2, o=8 → ones slot seg=00, tens slot seg=24, hundreds slot seg=79. frame_tick pulses once every 24 cycles.

REQ-020 load h=0, t=0, o=7 with BLANK_LZ=1 → hundreds and tens slots seg=7F, ones slot seg=78. Same with BLANK_LZ=0 → 40, 40, 78.

REQ-021 load h=0, t=12, o=5 → tens slot seg=3F (dash). Tens is not blanked; hundreds slot seg=7F.

REQ-022 rst_n pulled low mid-DRIVE of the tens slot → an=111 and seg=7F asynchronously. After release, the scan restarts at ones with shadows zeroed.

REQ-023 load asserted on the cnt=DIV-1 edge → the next slot shows the new digit. No cycle ever has more than one an bit low (checked by assertion).
